pll_lock_supervisor: RTL and testbench



---
 rtl/pll_lock_supervisor_if.sv | 29 ++
 rtl/pll_lock_supervisor.sv | 152 +++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_if.sv
// PLL-side and status signals of pll_lock_supervisor, bundled for the module port.
// master = the supervisor, slave = whatever observes it and drives the PLL LOCK input.
interface pll_lock_supervisor_if #(
    parameter int RETRY_W = 4
);
    logic               pll_lock;
    logic               clear_counts;
    logic               pll_resetb;
    logic               sys_reset;
    logic               ready;
    logic               lock_lost;
    logic [RETRY_W-1:0] retry_count;
    logic [7:0]         loss_count;
    logic [1:0]         state_dbg;

    // No valid/ready handshake here: every output is a registered level,
    // except lock_lost, which is a one-clock pulse.
    modport master (
        input  pll_lock, clear_counts,
        output pll_resetb, sys_reset, ready, lock_lost,
        output retry_count, loss_count, state_dbg
    );

    modport slave (
        output pll_lock, clear_counts,
        input  pll_resetb, sys_reset, ready, lock_lost,
        input  retry_count, loss_count, state_dbg
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences iCE40 PLL reset/lock and gates the system reset of the PLL clock domain.
// Optional macro PLL_LOCK_GLITCH_FILTER_EN: in RUN, ignore lock dropouts shorter than 3 clocks.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int RETRY_W        = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pll_lock_supervisor_if.master   bus
);
    localparam int MAX_A   = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef PLL_LOCK_GLITCH_FILTER_EN
    localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(2);
`endif

    localparam logic [1:0] S_PLL_RST   = 2'd0;
    localparam logic [1:0] S_WAIT_LOCK = 2'd1;
    localparam logic [1:0] S_STABLE    = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sync_q, sync_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [7:0]         loss_q, loss_d;
    logic               lost_q, lost_d;
    logic               pll_resetb_q, pll_resetb_d;
    logic               sys_reset_q, sys_reset_d;
    logic               ready_q, ready_d;
    logic               lock_s;
    logic               loss_event;

    assign lock_s = sync_q[1];

    // LOCK is meaningless while the PLL is held in reset, so the synchronizer is
    // flushed then; a stale high from the previous attempt cannot leak forward.
    always_comb begin
        sync_d = 2'b00;
        if (pll_resetb_q) begin
            sync_d = {sync_q[0], bus.pll_lock};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        retry_d    = retry_q;
        loss_d     = loss_q;
        loss_event = 1'b0;
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                    if (retry_q != '1) retry_d = retry_q + 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STB_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
`ifdef PLL_LOCK_GLITCH_FILTER_EN
                // Counter tracks consecutive low clocks of lock_s.
                if (lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOSS_LAST) begin
                    loss_event = 1'b1;
                end
`else
                cnt_d = '0;
                if (!lock_s) loss_event = 1'b1;
`endif
                if (loss_event) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end
            end
            default: begin
                state_d = S_PLL_RST;
                cnt_d   = '0;
            end
        endcase
        if (bus.clear_counts) begin
            retry_d = '0;
            loss_d  = '0;
        end
    end

    // Outputs are registered from the next state so they always match state_q.
    always_comb begin
        pll_resetb_d = (state_d != S_PLL_RST);
        sys_reset_d  = (state_d != S_RUN);
        ready_d      = (state_d == S_RUN);
        lost_d       = loss_event;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_PLL_RST;
            cnt_q        <= '0;
            sync_q       <= 2'b00;
            retry_q      <= '0;
            loss_q       <= '0;
            lost_q       <= 1'b0;
            pll_resetb_q <= 1'b0;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync_q       <= sync_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            lost_q       <= lost_d;
            pll_resetb_q <= pll_resetb_d;
            sys_reset_q  <= sys_reset_d;
            ready_q      <= ready_d;
        end
    end

    assign bus.pll_resetb  = pll_resetb_q;
    assign bus.sys_reset   = sys_reset_q;
    assign bus.ready       = ready_q;
    assign bus.lock_lost   = lost_q;
    assign bus.retry_count = retry_q;
    assign bus.loss_count  = loss_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with PLL_RST=4, STABLE=8, TIMEOUT=32.
// Expectations follow PLL_LOCK_GLITCH_FILTER_EN when it is defined for the build.
module tb_pll_lock_supervisor;
    localparam int PLL_RST_CYCLES = 4;
    localparam int STABLE_CYCLES  = 8;
    localparam int TIMEOUT_CYCLES = 32;
    localparam int RETRY_W        = 4;

`ifdef PLL_LOCK_GLITCH_FILTER_EN
    localparam int EXP2_FIRST  = -1;
    localparam int EXP2_RBLOW  = 0;
    localparam int EXP2_RDYLOW = 0;
    localparam int EXP2_LOSS   = 0;
    localparam int EXP5_FIRST  = 5;
`else
    localparam int EXP2_FIRST  = 3;
    localparam int EXP2_RBLOW  = 4;
    localparam int EXP2_RDYLOW = 10;
    localparam int EXP2_LOSS   = 1;
    localparam int EXP5_FIRST  = 3;
`endif

    typedef struct {
        logic       lock;
        logic       clr;
        logic [1:0] st;
        logic       resetb;
        logic       sysr;
        logic       rdy;
        logic       lost;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pll_lock_supervisor_if #(.RETRY_W(RETRY_W)) bus ();

    pll_lock_supervisor #(
        .PLL_RST_CYCLES (PLL_RST_CYCLES),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .RETRY_W        (RETRY_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int lost_pulses = 0;
    int first_lost, rb_low, rdy_low;
    logic [15:0] exp_q[$];
    vec_t vecs[20];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.lock_lost) lost_pulses++;
        check("sys_reset_vs_ready", int'(bus.sys_reset), int'(!bus.ready));
    endtask

    task automatic apply_reset(input logic lock);
        rst_n = 1'b0;
        bus.pll_lock = lock;
        bus.clear_counts = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        cyc = 0;
        lost_pulses = 0;
    endtask

    task automatic wait_ready(input int budget, input string name);
        int n = 0;
        while (!bus.ready && n < budget) begin
            step();
            n++;
        end
        check(name, int'(bus.ready), 1);
    endtask

    task automatic drop_and_watch(input int low_cycles, input int window,
                                  output int first, output int resetb_low, output int ready_low);
        first = -1;
        resetb_low = 0;
        ready_low = 0;
        bus.pll_lock = 1'b0;
        for (int k = 1; k <= window; k++) begin
            step();
            if (k == low_cycles) bus.pll_lock = 1'b1;
            if (bus.lock_lost && first < 0) first = k;
            if (!bus.pll_resetb) resetb_low++;
            if (!bus.ready) ready_low++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, int'(bus.state_dbg), 0);
        check({tag, "_pll_resetb"}, int'(bus.pll_resetb), 0);
        check({tag, "_sys_reset"}, int'(bus.sys_reset), 1);
        check({tag, "_ready"}, int'(bus.ready), 0);
        check({tag, "_lock_lost"}, int'(bus.lock_lost), 0);
        check({tag, "_retry"}, int'(bus.retry_count), 0);
        check({tag, "_loss"}, int'(bus.loss_count), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Edge-by-edge expectations after reset release with pll_lock high:
        // PLL_RST through edge 3, WAIT_LOCK 4-6 (synchronizer refill), STABLE 7-14, RUN from 15.
        for (int i = 0; i < 20; i++) begin
            vecs[i].lock   = 1'b1;
            vecs[i].clr    = (i == 10);
            vecs[i].st     = (i < 3) ? 2'd0 : (i < 6) ? 2'd1 : (i < 14) ? 2'd2 : 2'd3;
            vecs[i].resetb = (i >= 3);
            vecs[i].sysr   = (i < 14);
            vecs[i].rdy    = (i >= 14);
            vecs[i].lost   = 1'b0;
        end

        // Reset values and the bring-up sequence.
        apply_reset(1'b1);
        rst_n = 1'b0;
        step();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            bus.pll_lock = vecs[i].lock;
            bus.clear_counts = vecs[i].clr;
            exp_q.push_back(16'({vecs[i].st, vecs[i].resetb, vecs[i].sysr, vecs[i].rdy, vecs[i].lost}));
            step();
            check($sformatf("vec[%0d]", i),
                  int'({bus.state_dbg, bus.pll_resetb, bus.sys_reset, bus.ready, bus.lock_lost}),
                  int'(exp_q.pop_front()));
        end
        bus.clear_counts = 1'b0;
        check("bringup_retry", int'(bus.retry_count), 0);

        // Asynchronous reset in RUN, checked before any clock edge.
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");

        // No lock: timeouts every 36 clocks, never ready.
        begin
            int prev_retry = 0;
            int ready_seen = 0;
            apply_reset(1'b0);
            for (int t = 36; t <= 180; t += 36) exp_q.push_back(16'(t));
            for (int k = 0; k < 200; k++) begin
                step();
                if (bus.ready) ready_seen++;
                if (int'(bus.retry_count) != prev_retry) begin
                    prev_retry = int'(bus.retry_count);
                    check("retry_edge", cyc, (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1);
                    check("resetb_at_timeout", int'(bus.pll_resetb), 0);
                end
            end
            check("nolock_retry", int'(bus.retry_count), 5);
            check("nolock_ready_seen", ready_seen, 0);
            check("nolock_pending", exp_q.size(), 0);
            exp_q.delete();
        end

        // One-clock dropout while STABLE count is 5.
        apply_reset(1'b1);
        repeat (10) step();
        bus.pll_lock = 1'b0;
        step();
        bus.pll_lock = 1'b1;
        step();
        step();
        check("stable_drop_state13", int'(bus.state_dbg), 1);
        step();
        check("stable_drop_state14", int'(bus.state_dbg), 2);
        repeat (7) step();
        check("stable_drop_ready21", int'(bus.ready), 0);
        step();
        check("stable_drop_ready22", int'(bus.ready), 1);
        check("stable_drop_loss", int'(bus.loss_count), 0);
        check("stable_drop_pulses", lost_pulses, 0);
        check("stable_drop_retry", int'(bus.retry_count), 0);

        // Two-clock dropout in RUN.
        apply_reset(1'b1);
        wait_ready(30, "run2_initial_ready");
        lost_pulses = 0;
        drop_and_watch(2, 12, first_lost, rb_low, rdy_low);
        check("run2_first_lost", first_lost, EXP2_FIRST);
        check("run2_resetb_low", rb_low, EXP2_RBLOW);
        check("run2_ready_low", rdy_low, EXP2_RDYLOW);
        check("run2_loss", int'(bus.loss_count), EXP2_LOSS);
        check("run2_pulses", lost_pulses, EXP2_LOSS);
        wait_ready(30, "run2_relock");

        // Five-clock dropout in RUN.
        apply_reset(1'b1);
        wait_ready(30, "run5_initial_ready");
        lost_pulses = 0;
        drop_and_watch(5, 12, first_lost, rb_low, rdy_low);
        check("run5_first_lost", first_lost, EXP5_FIRST);
        check("run5_resetb_low", rb_low, 4);
        check("run5_loss", int'(bus.loss_count), 1);
        check("run5_pulses", lost_pulses, 1);
        wait_ready(30, "run5_relock");

        // clear_counts on the timeout clock wins over the increment.
        apply_reset(1'b0);
        repeat (35) step();
        bus.clear_counts = 1'b1;
        step();
        bus.clear_counts = 1'b0;
        check("clr_on_timeout_retry", int'(bus.retry_count), 0);
        check("clr_on_timeout_state", int'(bus.state_dbg), 0);
        repeat (36) step();
        check("retry_after_clr", int'(bus.retry_count), 1);
        bus.clear_counts = 1'b1;
        step();
        bus.clear_counts = 1'b0;
        check("clr_retry", int'(bus.retry_count), 0);
        check("clr_state", int'(bus.state_dbg), 0);

        // 260 loss events: loss_count saturates at 255, pulses keep coming.
        apply_reset(1'b1);
        wait_ready(30, "sat_initial_ready");
        lost_pulses = 0;
        for (int e = 1; e <= 260; e++) begin
            drop_and_watch(5, 8, first_lost, rb_low, rdy_low);
            wait_ready(40, "sat_relock");
            if (e == 255) check("loss_at_255", int'(bus.loss_count), 255);
        end
        check("loss_saturated", int'(bus.loss_count), 255);
        check("sat_pulses", lost_pulses, 260);
        bus.clear_counts = 1'b1;
        step();
        bus.clear_counts = 1'b0;
        check("clr_loss", int'(bus.loss_count), 0);
        check("clr_keeps_run", int'(bus.ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
